// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the VRAM port between the gfx fetcher and buffered CPU byte accesses
module vram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        gfx_active,
    input  logic [12:0] gfx_vaddr,
    output logic [15:0] gfx_vdata,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wrdata,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic        cpu_busy,
    output logic [7:0]  cpu_rddata,
    output logic        cpu_rdvalid,
    output logic [12:0] ram_addr,
    output logic [15:0] ram_wrdata,
    output logic [1:0]  ram_bytesel,
    output logic        ram_wren,
    input  logic [15:0] ram_rddata
);
    localparam logic [1:0] RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_DATA = 2'd2;
    logic [12:0] q_addr [2];
    logic [7:0]  q_data [2];
    logic [1:0]  q_sel;
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count, count_nxt;
    logic [1:0]  rd_state, rd_nxt;
    logic [12:0] rd_addr;
    logic        rd_sel;
    logic [7:0]  rd_hold;
    logic        push, pop, issue_rd;
    // Queue/read control and the port mux; writes always drain before a pending read issues
    always_comb begin
        push        = cpu_wr & (count != 2'd2);
        pop         = !gfx_active & (count != 2'd0);
        issue_rd    = !gfx_active & (count == 2'd0) & (rd_state == RD_WAIT);
        count_nxt   = count + {1'b0, push} - {1'b0, pop};
        rd_nxt      = (rd_state == RD_IDLE) ? (cpu_rd ? RD_WAIT : RD_IDLE) :
                      (rd_state == RD_WAIT) ? (issue_rd ? RD_DATA : RD_WAIT) : RD_IDLE;
        ram_wren    = pop;
        ram_addr    = pop ? q_addr[rd_ptr] : issue_rd ? rd_addr : gfx_vaddr;
        ram_wrdata  = pop ? {2{q_data[rd_ptr]}} : 16'h0000;
        ram_bytesel = pop ? (q_sel[rd_ptr] ? 2'b10 : 2'b01) : 2'b00;
        cpu_rdvalid = (rd_state == RD_DATA);
        cpu_rddata  = cpu_rdvalid ? (rd_sel ? ram_rddata[15:8] : ram_rddata[7:0]) : rd_hold;
        gfx_vdata   = ram_rddata;
    end
    // Control state; reset drops queued writes and any pending read immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_state <= RD_IDLE;
            cpu_busy <= 1'b0;
            rd_hold  <= 8'h00;
            rd_addr  <= 13'h0000;
            rd_sel   <= 1'b0;
        end else begin
            count    <= count_nxt;
            rd_ptr   <= rd_ptr ^ pop;
            wr_ptr   <= wr_ptr ^ push;
            rd_state <= rd_nxt;
            cpu_busy <= (count_nxt == 2'd2) | (rd_nxt != RD_IDLE);
            if (cpu_rdvalid) rd_hold <= cpu_rddata;
            if (rd_state == RD_IDLE && cpu_rd) begin
                rd_addr <= cpu_addr[13:1];
                rd_sel  <= cpu_addr[0];
            end
        end
    end
    // Queue storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= cpu_addr[13:1];
            q_data[wr_ptr] <= cpu_wrdata;
            q_sel[wr_ptr]  <= cpu_addr[0];
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus with a scoreboard of expected VRAM writes and CPU read bytes
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        gfx_active;
    logic [12:0] gfx_vaddr;
    logic [15:0] gfx_vdata;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_wr, cpu_rd;
    logic        cpu_busy;
    logic [7:0]  cpu_rddata;
    logic        cpu_rdvalid;
    logic [12:0] ram_addr;
    logic [15:0] ram_wrdata;
    logic [1:0]  ram_bytesel;
    logic        ram_wren;
    logic [15:0] ram_rddata = 16'h0000;
    logic [15:0] mem [8192];
    logic [30:0] wq [$];
    logic [7:0]  rq [$];
    int checks = 0;
    int failures = 0;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .gfx_active(gfx_active), .gfx_vaddr(gfx_vaddr),
        .gfx_vdata(gfx_vdata), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_busy(cpu_busy), .cpu_rddata(cpu_rddata),
        .cpu_rdvalid(cpu_rdvalid), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
        .ram_bytesel(ram_bytesel), .ram_wren(ram_wren), .ram_rddata(ram_rddata)
    );

    always #5 clk = ~clk;

    // Synchronous VRAM model with byte enables and one-cycle read latency
    always @(posedge clk) begin
        if (ram_wren && ram_bytesel[0]) mem[ram_addr][7:0] <= ram_wrdata[7:0];
        if (ram_wren && ram_bytesel[1]) mem[ram_addr][15:8] <= ram_wrdata[15:8];
        ram_rddata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every VRAM write and every read completion is matched against the scoreboard
    always @(negedge clk) begin
        if (ram_wren) begin
            if (wq.size() == 0) check("sb_wr_expected", wq.size(), 1);
            else check("sb_wr", {1'b0, ram_addr, ram_wrdata, ram_bytesel}, {1'b0, wq.pop_front()});
        end
        if (cpu_rdvalid) begin
            if (rq.size() == 0) check("sb_rd_expected", rq.size(), 1);
            else check("sb_rd", cpu_rddata, rq.pop_front());
        end
    end

    initial begin
        int bad;
        int cnt;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        reset = 1'b1; gfx_active = 1'b0; gfx_vaddr = 13'h0ABC;
        cpu_addr = '0; cpu_wrdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        #3;
        check("rst_ram_addr", ram_addr, 13'h0ABC);
        check("rst_wren", ram_wren, 0);
        check("rst_bytesel", ram_bytesel, 0);
        check("rst_wrdata", ram_wrdata, 0);
        check("rst_busy", cpu_busy, 0);
        check("rst_rdvalid", cpu_rdvalid, 0);
        check("rst_rddata", cpu_rddata, 0);
        step(); step();
        reset = 1'b0;
        step();
        // single write, one-cycle latency
        cpu_addr = 14'h0101; cpu_wrdata = 8'hA5; cpu_wr = 1'b1;
        wq.push_back({13'h0080, 16'hA5A5, 2'b10});
        step();
        cpu_wr = 1'b0;
        @(negedge clk);
        check("wr_lat_wren", ram_wren, 1);
        check("wr_lat_addr", ram_addr, 13'h0080);
        step();
        @(negedge clk);
        check("wr_once", ram_wren, 0);
        // write and read strobed together: write issues first
        step();
        cpu_addr = 14'h0200; cpu_wrdata = 8'h3C; cpu_wr = 1'b1; cpu_rd = 1'b1;
        wq.push_back({13'h0100, 16'h3C3C, 2'b01});
        rq.push_back(8'h3C);
        step();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        check("rar_wr_first", ram_wren, 1);
        check("rar_busy", cpu_busy, 1);
        step();
        @(negedge clk);
        check("rar_rd_wren", ram_wren, 0);
        check("rar_rd_addr", ram_addr, 13'h0100);
        check("rar_rd_novalid", cpu_rdvalid, 0);
        step();
        @(negedge clk);
        check("rar_rdvalid", cpu_rdvalid, 1);
        check("rar_rddata", cpu_rddata, 8'h3C);
        step();
        @(negedge clk);
        check("rar_pulse", cpu_rdvalid, 0);
        check("rar_hold", cpu_rddata, 8'h3C);
        check("rar_busy_clr", cpu_busy, 0);
        // gfx ownership with a full queue; third write dropped
        step();
        gfx_active = 1'b1; gfx_vaddr = 13'h0010;
        cpu_addr = 14'h0400; cpu_wrdata = 8'h11; cpu_wr = 1'b1;
        wq.push_back({13'h0200, 16'h1111, 2'b01});
        step();
        cpu_addr = 14'h0403; cpu_wrdata = 8'h22;
        wq.push_back({13'h0201, 16'h2222, 2'b10});
        @(negedge clk);
        check("full_busy_one", cpu_busy, 0);
        step();
        cpu_addr = 14'h0404; cpu_wrdata = 8'h33;
        @(negedge clk);
        check("full_busy_two", cpu_busy, 1);
        step();
        cpu_wr = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            gfx_vaddr = 13'(i * 37);
            @(negedge clk);
            if (ram_wren !== 1'b0 || ram_addr !== gfx_vaddr || cpu_busy !== 1'b1) bad++;
            step();
        end
        check("gfx_hold_errs", bad, 0);
        gfx_active = 1'b0;
        @(negedge clk);
        check("gfx_fall_wr1", {ram_wren, ram_addr}, {1'b1, 13'h0200});
        step();
        @(negedge clk);
        check("gfx_fall_wr2", {ram_wren, ram_addr}, {1'b1, 13'h0201});
        step();
        @(negedge clk);
        check("full_third_dropped", ram_wren, 0);
        check("full_busy_clr", cpu_busy, 0);
        // read straddling the start of a gfx burst
        step();
        cpu_addr = 14'h0601; cpu_wrdata = 8'hBE; cpu_wr = 1'b1;
        wq.push_back({13'h0300, 16'hBEBE, 2'b10});
        step();
        cpu_addr = 14'h0600; cpu_wrdata = 8'hEF;
        wq.push_back({13'h0300, 16'hEFEF, 2'b01});
        step();
        cpu_wr = 1'b0;
        step(); step();
        cpu_addr = 14'h0601; cpu_rd = 1'b1;
        rq.push_back(8'hBE);
        step();
        cpu_rd = 1'b0;
        @(negedge clk);
        check("straddle_issue", ram_addr, 13'h0300);
        step();
        gfx_active = 1'b1; gfx_vaddr = 13'h0055;
        @(negedge clk);
        check("straddle_gfx_addr", ram_addr, 13'h0055);
        check("straddle_rdvalid", cpu_rdvalid, 1);
        check("straddle_rddata", cpu_rddata, 8'hBE);
        // async reset with queued writes and a pending read
        step();
        gfx_vaddr = 13'h0077;
        cpu_addr = 14'h0800; cpu_wrdata = 8'h5A; cpu_wr = 1'b1;
        step();
        cpu_addr = 14'h0802; cpu_rd = 1'b1;
        step();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", cpu_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", cpu_busy, 0);
        check("arst_wren", ram_wren, 0);
        check("arst_rdvalid", cpu_rdvalid, 0);
        check("arst_rddata", cpu_rddata, 0);
        check("arst_addr", ram_addr, 13'h0077);
        check("arst_bytesel", ram_bytesel, 0);
        check("arst_wrdata", ram_wrdata, 0);
        gfx_active = 1'b0;
        step(); step();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_wren || cpu_rdvalid) cnt++;
            step();
        end
        check("no_access_after_reset", cnt, 0);
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
